mem_port_arbiter: RTL and testbench

//  Shares one single-port, 1-cycle-read-latency SRAM between two requesters.
//  m0 is the CPU data port (LW/SW address, byte-write mask, store data).
//  m1 is a secondary master (DMA / program loader).

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_rr_arb2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master SRAM port arbiter: FSM encoding and
// requester indices.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick: a lone requester always wins, and on a
// tie the requester that was not served last wins.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    winner = M0;
    any    = |req;
    case (req)
      2'b01:   winner = M0;
      2'b10:   winner = M1;
      2'b11:   winner = ~last;
      default: winner = M0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port, 1-cycle-read-latency SRAM between two req/gnt/rvalid
// masters; one access every three cycles, round-robin on contention.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int   ADDR_W    = 32,
  parameter int   DATA_W    = 32,
  parameter logic FIRST_GNT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_req,
  input  logic [DATA_W/8-1:0] m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,

  input  logic                m1_req,
  input  logic [DATA_W/8-1:0] m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,

  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e state;
  logic       last_owner;
  logic       owner;
  logic       is_read;

  logic              win;
  logic              any_req;
  logic [BE_W-1:0]   sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req    ({m1_req, m0_req}),
    .last   (last_owner),
    .winner (win),
    .any    (any_req)
  );

  assign sel_we    = (win == M1) ? m1_we    : m0_we;
  assign sel_addr  = (win == M1) ? m1_addr  : m0_addr;
  assign sel_wdata = (win == M1) ? m1_wdata : m0_wdata;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= ~FIRST_GNT;
      owner      <= M0;
      is_read    <= 1'b0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            is_read   <= (sel_we == '0);
            owner     <= win;
            m0_gnt    <= (win == M0);
            m1_gnt    <= (win == M1);
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= '0;
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          state  <= RESPOND;
        end
        RESPOND: begin
          // Writes complete with rvalid but leave the owner's last read data in place.
          if (owner == M0) begin
            m0_rvalid <= 1'b1;
            if (is_read) m0_rdata <= mem_rdata;
          end else begin
            m1_rvalid <= 1'b1;
            if (is_read) m1_rdata <= mem_rdata;
          end
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses from a
// reference memory model, a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [3:0]  we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        preload = 1'b1;

  logic [31:0] sram    [64];
  logic [31:0] ref_mem [64];
  logic [31:0] last_rdata [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          gnt_log [$];
  int          n_checks = 0;
  int          n_fail = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIRST_GNT(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (req[0]),
    .m0_we     (we[0]),
    .m0_addr   (addr[0]),
    .m0_wdata  (wdata[0]),
    .m0_gnt    (gnt[0]),
    .m0_rvalid (rvalid[0]),
    .m0_rdata  (rdata[0]),
    .m1_req    (req[1]),
    .m1_we     (we[1]),
    .m1_addr   (addr[1]),
    .m1_wdata  (wdata[1]),
    .m1_gnt    (gnt[1]),
    .m1_rvalid (rvalid[1]),
    .m1_rdata  (rdata[1]),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-masked write, registered read one cycle after mem_en.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) sram[i] <= ref_mem[i];
    end else if (mem_en) begin
      if (mem_we == 4'h0) mem_rdata <= sram[mem_addr[7:2]];
      else
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) sram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int r);
    return (r == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_front(input int r);
    return (r == 0) ? q0[0] : q1[0];
  endfunction

  task automatic q_pop(input int r, output exp_t e);
    if (r == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  // Reference model: serve the access against ref_mem and predict the response.
  task automatic issue(input int r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.we = w; e.addr = a; e.wdata = d;
    if (w == 4'h0) begin
      e.rdata       = ref_mem[a[7:2]];
      last_rdata[r] = e.rdata;
    end else begin
      for (int b = 0; b < 4; b++)
        if (w[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
      e.rdata = last_rdata[r];
    end
    if (r == 0) q0.push_back(e);
    else        q1.push_back(e);
    req[r] = 1'b1; we[r] = w; addr[r] = a; wdata[r] = d;
  endtask

  task automatic complete(input int r, output int gl, output int rl);
    gl = 0; rl = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (gnt[r]) begin gl = i; break; end
    end
    check($sformatf("gnt_seen_m%0d", r), gl != 0, 1);
    req[r] = 1'b0;
    if (gl == 0) return;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (rvalid[r]) begin rl = gl + i; break; end
    end
    check($sformatf("rvalid_seen_m%0d", r), rl != 0, 1);
  endtask

  task automatic drive_txn(input int r, input logic [3:0] w, input logic [31:0] a,
                           input logic [31:0] d, output int gl, output int rl);
    issue(r, w, a, d);
    complete(r, gl, rl);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {gnt, rvalid, mem_en, mem_we}, 0);
    check({tag, "_rdata0"}, rdata[0], 0);
    check({tag, "_rdata1"}, rdata[1], 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
  endtask

  task automatic rand_driver(input int r, input int n);
    int gl, rl, word;
    logic [3:0] w;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      word = (r == 0) ? $urandom_range(16, 39) : $urandom_range(40, 63);
      w    = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
      drive_txn(r, w, {24'h0, 6'(word), 2'($urandom)}, $urandom, gl, rl);
    end
  endtask

  // Monitor: grant rule, command routing, response data and latency.
  initial begin : monitor
    int   cycle = 0;
    int   last_granted = 1;
    int   gnt_cyc [2];
    int   exp_w;
    logic [1:0] prev_req = '0;
    logic prev_rst = 1'b1;
    exp_t e;
    gnt_cyc[0] = 0; gnt_cyc[1] = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (gnt != 0)    check("gnt_onehot", $countones(gnt), 1);
      if (rvalid != 0) check("rvalid_onehot", $countones(rvalid), 1);
      if (mem_en || gnt != 0) check("mem_en_with_gnt", mem_en, |gnt);
      for (int r = 0; r < 2; r++) begin
        if (gnt[r]) begin
          if (prev_rst || prev_req == 2'b00) exp_w = 2;
          else if (prev_req == 2'b11)        exp_w = 1 - last_granted;
          else                               exp_w = (prev_req == 2'b10) ? 1 : 0;
          check("arb_winner", r, exp_w);
          check($sformatf("gnt_has_expect_m%0d", r), q_size(r) > 0, 1);
          if (q_size(r) > 0) begin
            e = q_front(r);
            check($sformatf("mem_cmd_m%0d", r), {mem_we, mem_addr, mem_wdata},
                  {e.we, e.addr, e.wdata});
          end
          last_granted = r;
          gnt_cyc[r]   = cycle;
          gnt_log.push_back(r);
        end
        if (rvalid[r]) begin
          check($sformatf("rvalid_has_expect_m%0d", r), q_size(r) > 0, 1);
          check($sformatf("rvalid_latency_m%0d", r), cycle - gnt_cyc[r], 2);
          if (q_size(r) > 0) begin
            q_pop(r, e);
            check($sformatf("rdata_m%0d", r), rdata[r], e.rdata);
          end
        end
      end
      if (rst) last_granted = 1;
      prev_req = req;
      prev_rst = rst;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int gl, rl, base;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[4]  = 32'hDEAD_BEEF;
    ref_mem[12] = 32'hAAAA_AAAA;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    for (int r = 0; r < 2; r++) begin we[r] = '0; addr[r] = '0; wdata[r] = '0; end

    // Reset held two cycles while m0 already requests.
    issue(0, 4'h0, 32'h10, 32'h0);
    @(posedge clk); #1;
    check_reset_outputs("rst_cyc1");
    @(posedge clk); #1;
    check_reset_outputs("rst_cyc2");
    rst = 1'b0;
    preload = 1'b0;
    complete(0, gl, rl);
    check("first_gnt_latency", gl, 1);

    // Plain read.
    drive_txn(0, 4'h0, 32'h10, 32'h0, gl, rl);
    check("read_gnt_lat", gl, 1);
    check("read_rvalid_lat", rl, 3);
    check("read_data", rdata[0], 32'hDEAD_BEEF);

    // Full-word write by m1, read back by m0.
    drive_txn(1, 4'hF, 32'h20, 32'h1234_5678, gl, rl);
    check("write_gnt_lat", gl, 1);
    check("write_rvalid_lat", rl, 3);
    drive_txn(0, 4'h0, 32'h20, 32'h0, gl, rl);
    check("readback_m1_write", rdata[0], 32'h1234_5678);

    // Partial write keeps upper bytes; rdata untouched by the write itself.
    drive_txn(0, 4'b0011, 32'h30, 32'h0000_5555, gl, rl);
    check("rdata_held_on_write", rdata[0], 32'h1234_5678);
    drive_txn(0, 4'h0, 32'h30, 32'h0, gl, rl);
    check("partial_write_readback", rdata[0], 32'hAAAA_5555);

    // Back-to-back: new req raised during rvalid is granted next cycle.
    drive_txn(0, 4'h0, 32'h10, 32'h0, gl, rl);
    drive_txn(0, 4'h0, 32'h14, 32'h0, gl, rl);
    check("b2b_gnt_lat", gl, 1);

    // Contention right after reset alternates starting with m0.
    do_reset();
    base = gnt_log.size();
    fork
      begin
        drive_txn(0, 4'h0, 32'h40, 32'h0, gl, rl);
        drive_txn(0, 4'h0, 32'h44, 32'h0, gl, rl);
      end
      begin
        int gl1, rl1;
        drive_txn(1, 4'h0, 32'hA0, 32'h0, gl1, rl1);
        drive_txn(1, 4'h0, 32'hA4, 32'h0, gl1, rl1);
      end
    join
    check("rr_gnt_count", gnt_log.size() - base, 4);
    if (gnt_log.size() - base == 4) begin
      check("rr_order0", gnt_log[base],     0);
      check("rr_order1", gnt_log[base + 1], 1);
      check("rr_order2", gnt_log[base + 2], 0);
      check("rr_order3", gnt_log[base + 3], 1);
    end

    // Reset during ACCESS drops the read.
    issue(0, 4'h0, 32'h10, 32'h0);
    gl = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (gnt[0]) begin gl = i; break; end
    end
    check("abort_gnt_seen", gl != 0, 1);
    rst = 1'b1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    q0.delete();
    check_reset_outputs("rst_in_access");
    rst = 1'b0;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    repeat (4) begin @(posedge clk); #1; end
    drive_txn(0, 4'h0, 32'h10, 32'h0, gl, rl);
    check("post_abort_gnt_lat", gl, 1);
    check("post_abort_rvalid_lat", rl, 3);
    check("post_abort_data", rdata[0], 32'hDEAD_BEEF);

    // Randomized concurrent traffic in disjoint word ranges.
    fork
      rand_driver(0, 30);
      rand_driver(1, 30);
    join
    repeat (4) begin @(posedge clk); #1; end
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
